// File: rtl/osnt_replay_pkg.sv
// Shared state encoding and default widths for the replay FIFO-to-memory writer.
package osnt_replay_pkg;

  localparam int LINE_W_DEF     = 144;
  localparam int NUM_Q_DEF      = 4;
  localparam int QID_W_DEF      = 2;
  localparam int DEPTH_BITS_DEF = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/replay_qptr_bank.sv
// Committed write pointer per replay queue, plus the queue-full compare
// against the reader pointer of a selected queue.
module replay_qptr_bank #(
  parameter int NUM_QUEUES       = 4,
  parameter int NUM_QUEUES_BITS  = 2,
  parameter int QUEUE_DEPTH_BITS = 17
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   commit_en,
  input  logic [NUM_QUEUES_BITS-1:0]             commit_qid,
  input  logic [QUEUE_DEPTH_BITS-1:0]            commit_ptr,
  input  logic [NUM_QUEUES_BITS-1:0]             lkp_qid,
  output logic [QUEUE_DEPTH_BITS-1:0]            lkp_ptr,
  input  logic [NUM_QUEUES_BITS-1:0]             chk_qid,
  input  logic [QUEUE_DEPTH_BITS-1:0]            chk_ptr,
  output logic                                   chk_full,
  input  logic [NUM_QUEUES*QUEUE_DEPTH_BITS-1:0] q_rd_ptr_flat,
  output logic [NUM_QUEUES*QUEUE_DEPTH_BITS-1:0] q_wr_ptr_flat
);

  localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ONE = QUEUE_DEPTH_BITS'(1);

  logic [QUEUE_DEPTH_BITS-1:0] ptr_q [NUM_QUEUES];
  logic [QUEUE_DEPTH_BITS-1:0] ptr_d [NUM_QUEUES];
  logic [QUEUE_DEPTH_BITS-1:0] rd_sel;
  logic [QUEUE_DEPTH_BITS-1:0] chk_nxt;

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      ptr_d[i] = ptr_q[i];
      if (commit_en && (commit_qid == NUM_QUEUES_BITS'(i))) ptr_d[i] = commit_ptr;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (reset) ptr_q[i] <= '0;
      else       ptr_q[i] <= ptr_d[i];
    end
  end

  always_comb begin
    lkp_ptr       = '0;
    rd_sel        = '0;
    q_wr_ptr_flat = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (lkp_qid == NUM_QUEUES_BITS'(i)) lkp_ptr = ptr_q[i];
      if (chk_qid == NUM_QUEUES_BITS'(i)) rd_sel = q_rd_ptr_flat[i*QUEUE_DEPTH_BITS +: QUEUE_DEPTH_BITS];
      q_wr_ptr_flat[i*QUEUE_DEPTH_BITS +: QUEUE_DEPTH_BITS] = ptr_q[i];
    end
  end

  // One slot is always left free so a full region never looks empty to the reader.
  assign chk_nxt  = chk_ptr + PTR_ONE;
  assign chk_full = (chk_nxt == rd_sel);

endmodule

// File: rtl/fifo_to_mem_writer.sv
// Drains a FWFT FIFO of packet lines into per-queue memory regions, committing
// pointers only on end-of-packet. Define FIFO_TO_MEM_WRITER_STATS_EN for counters.
//
// state | meaning
// IDLE  | waiting for the first line of a packet
// WRITE | writing lines of cur_qid's packet until EOP
// DROP  | discarding the rest of a packet that did not fit
module fifo_to_mem_writer
  import osnt_replay_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = LINE_W_DEF,
  parameter int NUM_QUEUES       = NUM_Q_DEF,
  parameter int NUM_QUEUES_BITS  = $clog2(NUM_QUEUES),
  parameter int QUEUE_DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [FIFO_DATA_WIDTH-1:0]                  fifo_dout,
  input  logic [NUM_QUEUES_BITS-1:0]                  fifo_dout_qid,
  input  logic                                        fifo_empty,
  output logic                                        fifo_rd_en,
  input  logic                                        mem_wr_ready,
  output logic                                        mem_wr_en,
  output logic [NUM_QUEUES_BITS+QUEUE_DEPTH_BITS-1:0] mem_wr_addr,
  output logic [FIFO_DATA_WIDTH-1:0]                  mem_wr_data,
  input  logic [NUM_QUEUES*QUEUE_DEPTH_BITS-1:0]      q_rd_ptr_flat,
  output logic [NUM_QUEUES*QUEUE_DEPTH_BITS-1:0]      q_wr_ptr_flat,
  output logic [31:0]                                 pkt_cnt,
  output logic [31:0]                                 drop_cnt
);

  localparam int AW = NUM_QUEUES_BITS + QUEUE_DEPTH_BITS;
  localparam logic [QUEUE_DEPTH_BITS-1:0] PTR_ONE = QUEUE_DEPTH_BITS'(1);

  wr_state_e                   state_q, state_d;
  logic [NUM_QUEUES_BITS-1:0]  cur_qid_q, cur_qid_d;
  logic [QUEUE_DEPTH_BITS-1:0] tmp_ptr_q, tmp_ptr_d;
  logic                        wr_en_q, wr_en_d;
  logic [AW-1:0]               wr_addr_q, wr_addr_d;
  logic [FIFO_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic                        is_eop;
  logic [NUM_QUEUES_BITS-1:0]  chk_qid;
  logic [QUEUE_DEPTH_BITS-1:0] chk_ptr;
  logic [QUEUE_DEPTH_BITS-1:0] nxt_ptr;
  logic [QUEUE_DEPTH_BITS-1:0] lkp_ptr;
  logic                        chk_full;
  logic                        commit_en;
  logic                        pkt_inc;
  logic                        drop_inc;

  assign fifo_rd_en = !reset && !fifo_empty && (mem_wr_ready || (state_q == DROP));

  // In IDLE the head line opens a packet, so the full check uses its own queue.
  assign is_eop  = (fifo_dout_qid != cur_qid_q);
  assign chk_qid = (state_q == IDLE) ? fifo_dout_qid : cur_qid_q;
  assign chk_ptr = (state_q == IDLE) ? lkp_ptr : tmp_ptr_q;
  assign nxt_ptr = chk_ptr + PTR_ONE;

  replay_qptr_bank #(
    .NUM_QUEUES       (NUM_QUEUES),
    .NUM_QUEUES_BITS  (NUM_QUEUES_BITS),
    .QUEUE_DEPTH_BITS (QUEUE_DEPTH_BITS)
  ) u_qptr_bank (
    .clk           (clk),
    .reset         (reset),
    .commit_en     (commit_en),
    .commit_qid    (cur_qid_q),
    .commit_ptr    (nxt_ptr),
    .lkp_qid       (fifo_dout_qid),
    .lkp_ptr       (lkp_ptr),
    .chk_qid       (chk_qid),
    .chk_ptr       (chk_ptr),
    .chk_full      (chk_full),
    .q_rd_ptr_flat (q_rd_ptr_flat),
    .q_wr_ptr_flat (q_wr_ptr_flat)
  );

  always_comb begin
    state_d   = state_q;
    cur_qid_d = cur_qid_q;
    tmp_ptr_d = tmp_ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    commit_en = 1'b0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_rd_en) begin
          cur_qid_d = fifo_dout_qid;
          tmp_ptr_d = lkp_ptr;
          if (!chk_full) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {chk_qid, chk_ptr};
            wr_data_d = fifo_dout;
            tmp_ptr_d = nxt_ptr;
            state_d   = WRITE;
          end else begin
            state_d   = DROP;
          end
        end
      end
      WRITE: begin
        if (fifo_rd_en) begin
          if (chk_full) begin
            // An EOP that does not fit has nothing left to discard.
            if (is_eop) begin
              drop_inc = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = DROP;
            end
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = {chk_qid, chk_ptr};
            wr_data_d = fifo_dout;
            tmp_ptr_d = nxt_ptr;
            if (is_eop) begin
              commit_en = 1'b1;
              pkt_inc   = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (fifo_rd_en && is_eop) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_qid_q <= '0;
      tmp_ptr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_qid_q <= cur_qid_d;
      tmp_ptr_q <= tmp_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;

`ifdef FIFO_TO_MEM_WRITER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pkt_inc)  pkt_cnt_d  = pkt_cnt_q + 32'd1;
    if (drop_inc) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = pkt_inc ^ drop_inc;
  assign pkt_cnt      = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_fifo_to_mem_writer.sv
// Scoreboard bench for fifo_to_mem_writer: a packet-level model predicts memory
// writes, committed pointers and counters; a monitor checks every write.
module tb_fifo_to_mem_writer;

  localparam int DW    = 144;
  localparam int NQ    = 4;
  localparam int NQB   = 2;
  localparam int QDB   = 8;
  localparam int AW    = NQB + QDB;
  localparam int DEPTH = 1 << QDB;

  logic               clk = 1'b0;
  logic               reset;
  logic [DW-1:0]      fifo_dout;
  logic [NQB-1:0]     fifo_dout_qid;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic               mem_wr_ready;
  logic               mem_wr_en;
  logic [AW-1:0]      mem_wr_addr;
  logic [DW-1:0]      mem_wr_data;
  logic [NQ*QDB-1:0]  q_rd_ptr_flat;
  logic [NQ*QDB-1:0]  q_wr_ptr_flat;
  logic [31:0]        pkt_cnt;
  logic [31:0]        drop_cnt;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [NQB-1:0] qid;
  } line_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  line_t fq[$];
  wr_t   exp_q[$];
  wr_t   mon_w;
  int    m_ptr[NQ];
  int    m_rd[NQ];
  int    m_pkt, m_drop;
  int    n_vec, n_err;
  int    bubble_pct, rdy_low_pct, stall_left, pops;

  fifo_to_mem_writer #(
    .FIFO_DATA_WIDTH  (DW),
    .NUM_QUEUES       (NQ),
    .NUM_QUEUES_BITS  (NQB),
    .QUEUE_DEPTH_BITS (QDB)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_dout     (fifo_dout),
    .fifo_dout_qid (fifo_dout_qid),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .mem_wr_ready  (mem_wr_ready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .q_rd_ptr_flat (q_rd_ptr_flat),
    .q_wr_ptr_flat (q_wr_ptr_flat),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    q_rd_ptr_flat = '0;
    for (int i = 0; i < NQ; i++) q_rd_ptr_flat[i*QDB +: QDB] = QDB'(m_rd[i]);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Packet model: lines fill the region from the committed pointer until the
  // slot just before the reader pointer; a packet that does not fit is dropped whole.
  task automatic send_pkt(input int q, input int n);
    int    p;
    bit    dropped;
    line_t ln;
    wr_t   w;
    p = m_ptr[q];
    dropped = 0;
    for (int i = 0; i < n; i++) begin
      ln.data = rand_data();
      ln.qid  = (i == n - 1) ? NQB'((q + 1) % NQ) : NQB'(q);
      fq.push_back(ln);
      if (!dropped) begin
        if (((p + 1) % DEPTH) == m_rd[q]) dropped = 1;
        else begin
          w.addr = AW'(q * DEPTH + p);
          w.data = ln.data;
          exp_q.push_back(w);
          p = (p + 1) % DEPTH;
        end
      end
    end
    if (dropped) m_drop++;
    else begin
      m_ptr[q] = p;
      m_pkt++;
    end
  endtask

  task automatic drive_cycle();
    bit stalled;
    @(negedge clk);
    stalled = 0;
    if (fq.size() > 0 && $urandom_range(99) >= bubble_pct) begin
      fifo_empty    = 1'b0;
      fifo_dout     = fq[0].data;
      fifo_dout_qid = fq[0].qid;
    end else begin
      fifo_empty    = 1'b1;
      fifo_dout     = rand_data();
      fifo_dout_qid = NQB'($urandom_range(NQ - 1));
    end
    if (stall_left > 0) begin
      mem_wr_ready = 1'b0;
      stall_left--;
      stalled = 1;
    end else begin
      mem_wr_ready = ($urandom_range(99) >= rdy_low_pct);
    end
    #1;
    if (fifo_empty) chk("rd_en_when_empty", fifo_rd_en, 0);
    if (stalled && !fifo_empty) chk("rd_en_during_stall", fifo_rd_en, 0);
    if (fifo_rd_en && !fifo_empty) begin
      void'(fq.pop_front());
      pops++;
    end
  endtask

  task automatic settle(input string tag);
    int guard;
    guard = 0;
    while (fq.size() > 0 && guard < 3000) begin
      drive_cycle();
      guard++;
    end
    if (fq.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain_timeout: %0d lines left, expected 0", tag, fq.size());
      fq.delete();
    end
    repeat (3) drive_cycle();
    chk({tag, "_writes_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
    for (int q = 0; q < NQ; q++)
      chk($sformatf("%s_wr_ptr%0d", tag, q), q_wr_ptr_flat[q*QDB +: QDB], m_ptr[q]);
`ifdef FIFO_TO_MEM_WRITER_STATS_EN
    chk({tag, "_pkt_cnt"}, pkt_cnt, m_pkt);
    chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
`else
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    fq.delete();
    fifo_empty    = 1'b0;
    fifo_dout     = rand_data();
    fifo_dout_qid = NQB'(1);
    mem_wr_ready  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("rd_en_in_reset", fifo_rd_en, 0);
      @(negedge clk);
    end
    fifo_empty = 1'b1;
    reset      = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      m_ptr[q] = 0;
      m_rd[q]  = 0;
    end
    m_pkt  = 0;
    m_drop = 0;
    #1;
    chk("reset_mem_wr_en", mem_wr_en, 0);
    chk("reset_mem_wr_addr", mem_wr_addr, 0);
    chk("reset_mem_wr_data", mem_wr_data, 0);
    chk("reset_wr_ptrs", q_wr_ptr_flat, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
  endtask

  // Monitor: every write strobe must match the next predicted write.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_wr_addr, mem_wr_data);
        end else begin
          mon_w = exp_q.pop_front();
          chk("wr_addr", mem_wr_addr, mon_w.addr);
          chk("wr_data", mem_wr_data, mon_w.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  guard;
    int  p;
    wr_t w;
    line_t ln;
    n_vec = 0; n_err = 0; m_pkt = 0; m_drop = 0;
    bubble_pct = 0; rdy_low_pct = 0; stall_left = 0; pops = 0;
    for (int q = 0; q < NQ; q++) begin
      m_ptr[q] = 0;
      m_rd[q]  = 0;
    end
    reset = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; fifo_dout_qid = '0; mem_wr_ready = 1'b1;
    do_reset(4);

    send_pkt(1, 4);
    settle("basic_q1");

    send_pkt(1, 8);
    pops = 0; guard = 0;
    while (pops < 3 && guard < 50) begin drive_cycle(); guard++; end
    stall_left = 3;
    settle("stall_q1");

    send_pkt(0, 5);
    settle("fill_q0");
    m_rd[0] = 8;
    send_pkt(0, 4);
    settle("drop_q0");

    send_pkt(2, 254);
    settle("fill_q2");
    m_rd[2] = 16;
    send_pkt(2, 4);
    settle("wrap_q2");

    m_rd[0] = 0;
    send_pkt(3, 3);
    send_pkt(0, 3);
    settle("eop_wrap_qid");

    for (int r = 0; r < 6; r++) begin
      bubble_pct  = $urandom_range(30);
      rdy_low_pct = $urandom_range(40);
      for (int q = 0; q < NQ; q++)
        m_rd[q] = (m_ptr[q] + (($urandom_range(1) == 1) ? $urandom_range(1, 12) : $urandom_range(13, 200))) % DEPTH;
      for (int k = 0; k < 6; k++) send_pkt($urandom_range(NQ - 1), $urandom_range(2, 8));
      settle($sformatf("rand%0d", r));
    end

    bubble_pct = 0; rdy_low_pct = 0;
    m_rd[1] = (m_ptr[1] + 50) % DEPTH;
    #1;
    p = m_ptr[1];
    for (int i = 0; i < 6; i++) begin
      ln.data = rand_data();
      ln.qid  = (i == 5) ? NQB'(2) : NQB'(1);
      fq.push_back(ln);
      if (i < 2) begin
        w.addr = AW'(DEPTH + (p + i) % DEPTH);
        w.data = ln.data;
        exp_q.push_back(w);
      end
    end
    pops = 0; guard = 0;
    while (pops < 2 && guard < 50) begin drive_cycle(); guard++; end
    do_reset(3);
    chk("midpkt_reset_writes_outstanding", exp_q.size(), 0);

    send_pkt(1, 3);
    settle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
